uart_rx: RTL and testbench
==========================

# uart_rx

Serial receiver for the SoC's UART: the inbound counterpart of the transmitter that drives the `TX` pin on `top`. Samples the asynchronous `RX` pin, decodes 8N1 frames, and buffers received bytes in a small FIFO. The CPU side drains the FIFO through a valid/ready handshake. Framing errors and overruns are reported as sticky flags. Sits between the `RX` pad of `top` and the CPU's memory-mapped I/O decode.

## Interface
Parameters:
- `CLK_DIV`, 16: system clocks per bit. Even, ≥ 4.
- `FIFO_DEPTH`, 4: receive FIFO entries. Power of two, ≥ 2.

Ports:
- `sys_clk_in`  in  1  system clock. Single clock domain.
- `sys_reset`  in  1  reset, asynchronous, active-low.
- `rx`  in  1  serial line. Asynchronous; idles high.
- `data_out`  out  8  FIFO head byte; valid only while `data_valid` is high.
- `data_valid`  out  1  FIFO not empty.
- `data_ready`  in  1  consumer pop strobe. A pop happens when `data_valid && data_ready`.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- `frame_err`  out  1  sticky: a stop bit was sampled low.
- `overrun`  out  1  sticky: a byte was dropped because the FIFO was full.
- `clear_err`  in  1  one-cycle pulse that clears both sticky flags.

## Operation
- `rx` passes through a 2-flop synchronizer, reset to 1. Edge detection compares the synchronizer output with its registered previous value.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
  - IDLE: a synchronized falling edge goes to START and loads the bit timer with `CLK_DIV/2-1`.
  - START: at timer expiry, sample the line.
    - Low: go to DATA, reload the timer with `CLK_DIV-1`, bit index = 0.
    - High: the edge was a glitch; return to IDLE with no side effects.
  - DATA: at each expiry, shift the sample in LSB first. After bit 7, go to STOP.
  - STOP: at expiry, sample the line.
    - High: push the byte and go to IDLE.
    - Low: set `frame_err`, discard the byte, go to WAIT_IDLE.
  - WAIT_IDLE: wait for the synchronized line to read 1, then go to IDLE. This absorbs breaks.
- FIFO push rules:
  - Push with the FIFO full and no pop in the same cycle: drop the byte and set `overrun`. FIFO contents are unchanged.
  - Push with the FIFO full and a pop in the same cycle: both operations happen, the byte is accepted, and the count is unchanged.
  - Push and pop in the same cycle at any other occupancy: the count is unchanged.
- Pop while empty is ignored.
- `clear_err` clears both sticky flags. If a flag is set in the same cycle as `clear_err`, the set wins.
- Pointers wrap modulo `FIFO_DEPTH`. `fifo_count` ranges from 0 to `FIFO_DEPTH`.
- Reset values:
  - FSM = IDLE, pointers = 0, `fifo_count` = 0.
  - `data_valid` = 0, `data_out` = 0.
  - `frame_err` = 0, `overrun` = 0.
  - Synchronizer flops = 1.
- Reset asserted mid-frame abandons the frame. After deassertion, the receiver returns to IDLE and first requires the synchronized line to read 1, so the tail of the frame cannot produce a false start.

## Timing
- Let T be the cycle in which the synchronized falling edge is detected. A pin edge at cycle 0 gives T = 2.
- Start sample at T+CLK_DIV/2. Bit n sample at T+CLK_DIV/2+(n+1)·CLK_DIV. Stop sample at T+CLK_DIV/2+9·CLK_DIV.
- The push is registered: `data_valid` and `fifo_count` update on the cycle after the stop sample.
- Example, `CLK_DIV`=16, pin edge at cycle 0: stop sample at cycle 154, `data_valid` high at cycle 155.
- `data_out` is a registered read of the head entry. It updates the cycle after a pop. It shows a new byte in the same cycle that `data_valid` rises from empty.
- Back-to-back frames are supported: a start edge may arrive in the cycle after the stop sample, with no dead time required.
- Throughput is one byte per 10·CLK_DIV cycles.

## Structure
- Shared package `uart_pkg`:
  - FSM state enum (`UART_IDLE` … `UART_WAIT_IDLE`).
  - `UART_DATA_BITS` = 8.
  - Timer width function shared with the transmitter.
- Sub-module `uart_rx_fifo`: synchronous FIFO with push/pop, full/empty, count, and same-cycle push+pop semantics. It is reusable for a future TX buffer.
- The top-level `uart_rx` contains the synchronizer, bit timer, FSM, shift register, and sticky flags.

## Test plan
- Single byte, `CLK_DIV`=16: send 0xA5 as an 8N1 frame starting at pin cycle 0 → `data_valid` at cycle 155, `data_out`=0xA5, `fifo_count`=1. After one cycle of `data_ready`: `data_valid`=0, count=0.
- Glitch: drive `rx` low for 4 cycles, then high → no push, no flags set, FSM back in IDLE. A subsequent 0x3C frame is received correctly.
- Frame error: send 0x55 with the stop bit driven low, then hold the line low for 40 bits, then release → `frame_err`=1, count=0. The next frame, 0x81, is received. `clear_err` clears `frame_err`.
- Overrun, `FIFO_DEPTH`=4, `data_ready`=0: send 0x01–0x05 back to back → count=4, `overrun`=1. Popping yields 0x01, 0x02, 0x03, 0x04.
- Full plus simultaneous pop: FIFO full, assert `data_ready` in the cycle the 5th byte pushes → the byte is accepted, count stays 4, `overrun`=0.
- Reset mid-frame: assert `sys_reset`=0 during bit 3 of 0xF0, release while `rx` is still mid-frame → all outputs at reset values and no byte is pushed from the partial frame. The next full frame, 0x0F, is received.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive (and future transmit) paths:
//   - uart_state_e     : receiver FSM state encoding
//   - UART_DATA_BITS   : payload bits per frame (8N1)
//   - uart_timer_width : width of a bit timer that counts 0 .. clk_div-1
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        UART_IDLE      = 3'd0,
        UART_START     = 3'd1,
        UART_DATA      = 3'd2,
        UART_STOP      = 3'd3,
        UART_WAIT_IDLE = 3'd4
    } uart_state_e;

    localparam int UART_DATA_BITS = 8;

    // Bits needed to hold clk_div-1; never less than one bit.
    function automatic int uart_timer_width(input int clk_div);
        int w;
        w = $clog2(clk_div);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
// Synchronous FIFO with a registered head-of-queue output.
// Ports:
//   clk_i        clock
//   rst_ni       asynchronous active-low reset
//   push_i       write request; dropped when full unless a pop happens too
//   push_data_i  write data
//   pop_i        read request; ignored when empty
//   rd_data_o    registered head entry (valid while !empty_o)
//   empty_o      no entries
//   full_o       DEPTH entries
//   count_o      occupancy 0 .. DEPTH
// -----------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    rd_ptr_nxt;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             do_push, do_pop;

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == CW'(DEPTH));
    assign count_o   = count_q;
    assign rd_data_o = rd_data_q;

    // A push into a full FIFO is only accepted when a pop frees the slot
    // in the same cycle.
    assign do_pop     = pop_i & ~empty_o;
    assign do_push    = push_i & (~full_o | do_pop);
    assign rd_ptr_nxt = rd_ptr_q + AW'(1);

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        rd_data_d = rd_data_q;

        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_nxt;
        end

        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // Head register: on a pop, load the next entry; if the only entry is
        // being popped while a new one arrives, forward the incoming byte
        // because the array write has not landed yet. A push into an empty
        // FIFO is forwarded so the byte appears together with !empty.
        if (do_pop) begin
            if (count_q > CW'(1)) begin
                rd_data_d = mem_q[rd_ptr_nxt];
            end else if (do_push) begin
                rd_data_d = push_data_i;
            end
        end else if (empty_o && do_push) begin
            rd_data_d = push_data_i;
        end
    end

    // Storage array has no reset so it can map onto RAM primitives.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rd_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rd_data_q <= rd_data_d;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// 8N1 UART receiver with a receive FIFO and sticky error flags.
// Ports:
//   sys_clk_in   system clock
//   sys_reset    asynchronous active-low reset
//   rx           asynchronous serial input, idles high
//   data_out     FIFO head byte (valid while data_valid)
//   data_valid   FIFO not empty
//   data_ready   pop strobe; pops when data_valid && data_ready
//   fifo_count   FIFO occupancy
//   frame_err    sticky: stop bit sampled low
//   overrun      sticky: byte dropped on a full FIFO
//   clear_err    pulse clearing both sticky flags (a same-cycle set wins)
// -----------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         sys_clk_in,
    input  logic                         sys_reset,
    input  logic                         rx,
    output logic [7:0]                   data_out,
    output logic                         data_valid,
    input  logic                         data_ready,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
    output logic                         frame_err,
    output logic                         overrun,
    input  logic                         clear_err
);

    localparam int TW = uart_timer_width(CLK_DIV);
    localparam int IW = $clog2(UART_DATA_BITS);
    localparam logic [TW-1:0] HALF_LOAD = TW'(CLK_DIV / 2 - 1);
    localparam logic [TW-1:0] FULL_LOAD = TW'(CLK_DIV - 1);
    localparam logic [IW-1:0] LAST_BIT  = IW'(UART_DATA_BITS - 1);

    // Synchronizer and edge detector
    logic       sync1_q, sync2_q, prev_q;
    logic [1:0] settle_q;
    logic       armed_q, armed_d;
    logic       fall;

    // Receive FSM datapath
    uart_state_e               state_q, state_d;
    logic [TW-1:0]             timer_q, timer_d;
    logic [IW-1:0]             bit_idx_q, bit_idx_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      push_q, push_d;
    logic                      expired;

    // Flags
    logic frame_err_q, frame_err_d, ferr_set;
    logic overrun_q, overrun_d, ovr_set;

    // FIFO status
    logic fifo_empty, fifo_full;

    assign fall    = prev_q & ~sync2_q;
    assign expired = (timer_q == '0);

    // settle_q marks when sync2_q carries a real pin sample rather than its
    // reset value. The receiver only arms once it has seen a genuine high
    // level, so a frame cut by reset cannot leave a false start behind.
    assign armed_d = armed_q | (settle_q[1] & sync2_q);

    always_ff @(posedge sys_clk_in or negedge sys_reset) begin
        if (!sys_reset) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            prev_q   <= 1'b1;
            settle_q <= 2'b00;
            armed_q  <= 1'b0;
        end else begin
            sync1_q  <= rx;
            sync2_q  <= sync1_q;
            prev_q   <= sync2_q;
            settle_q <= {settle_q[0], 1'b1};
            armed_q  <= armed_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = expired ? timer_q : timer_q - TW'(1);
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        push_d    = 1'b0;
        ferr_set  = 1'b0;

        case (state_q)
            UART_IDLE: begin
                if (armed_q && fall) begin
                    state_d = UART_START;
                    timer_d = HALF_LOAD;
                end
            end
            UART_START: begin
                if (expired) begin
                    if (!sync2_q) begin
                        state_d   = UART_DATA;
                        timer_d   = FULL_LOAD;
                        bit_idx_d = '0;
                    end else begin
                        state_d = UART_IDLE;
                    end
                end
            end
            UART_DATA: begin
                if (expired) begin
                    shift_d = {sync2_q, shift_q[UART_DATA_BITS-1:1]};
                    timer_d = FULL_LOAD;
                    if (bit_idx_q == LAST_BIT) begin
                        state_d = UART_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + IW'(1);
                    end
                end
            end
            UART_STOP: begin
                if (expired) begin
                    if (sync2_q) begin
                        push_d  = 1'b1;
                        state_d = UART_IDLE;
                    end else begin
                        ferr_set = 1'b1;
                        state_d  = UART_WAIT_IDLE;
                    end
                end
            end
            UART_WAIT_IDLE: begin
                if (sync2_q) begin
                    state_d = UART_IDLE;
                end
            end
            default: state_d = UART_IDLE;
        endcase
    end

    // A full FIFO only drops the byte when no pop frees a slot.
    assign ovr_set     = push_q & fifo_full & ~data_ready;
    assign frame_err_d = ferr_set | (frame_err_q & ~clear_err);
    assign overrun_d   = ovr_set  | (overrun_q   & ~clear_err);

    always_ff @(posedge sys_clk_in or negedge sys_reset) begin
        if (!sys_reset) begin
            state_q     <= UART_IDLE;
            timer_q     <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            push_q      <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            push_q      <= push_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    // shift_q stays stable for many cycles after the stop sample, so the
    // registered push can take it directly.
    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_DATA_BITS)
    ) u_fifo (
        .clk_i       (sys_clk_in),
        .rst_ni      (sys_reset),
        .push_i      (push_q),
        .push_data_i (shift_q),
        .pop_i       (data_ready),
        .rd_data_o   (data_out),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full),
        .count_o     (fifo_count)
    );

    assign data_valid = ~fifo_empty;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Directed bench for uart_rx with CLK_DIV=16, FIFO_DEPTH=4. Inputs change
// 1 time unit after a rising edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_uart_rx;

    localparam int CLK_DIV    = 16;
    localparam int FIFO_DEPTH = 4;

    logic       clk = 1'b0;
    logic       sys_reset;
    logic       rx;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ready;
    logic [2:0] fifo_count;
    logic       frame_err;
    logic       overrun;
    logic       clear_err;

    int n_checks = 0;
    int n_errors = 0;

    uart_rx #(
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .sys_clk_in (clk),
        .sys_reset  (sys_reset),
        .rx         (rx),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .fifo_count (fifo_count),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .clear_err  (clear_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Step to just after the next rising edge.
    task automatic align();
        @(posedge clk);
        #1;
    endtask

    // Must be called just after a rising edge; leaves just after one.
    // The start bit is first sampled on the next rising edge.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        logic [9:0] bits;
        bits = {stop_bit, b, 1'b0};
        $display("tx frame 0x%02h stop=%0b", b, stop_bit);
        for (int i = 0; i < 10; i++) begin
            rx = bits[i];
            repeat (CLK_DIV) @(posedge clk);
            #1;
        end
    endtask

    // Check the head byte, then pop it with a one-cycle data_ready.
    task automatic pop_check(input string tag, input logic [7:0] exp);
        @(negedge clk);
        check_eq({tag, " valid"}, 32'(data_valid), 32'd1);
        check_eq({tag, " data"},  32'(data_out),   32'(exp));
        $display("pop 0x%02h", data_out);
        data_ready = 1'b1;
        @(posedge clk);
        #1;
        data_ready = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clear_err = 1'b1;
        @(posedge clk);
        #1;
        clear_err = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        sys_reset  = 1'b0;
        rx         = 1'b1;
        data_ready = 1'b0;
        clear_err  = 1'b0;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        check_eq("rst data_valid", 32'(data_valid), 32'd0);
        check_eq("rst data_out",   32'(data_out),   32'd0);
        check_eq("rst fifo_count", 32'(fifo_count), 32'd0);
        check_eq("rst frame_err",  32'(frame_err),  32'd0);
        check_eq("rst overrun",    32'(overrun),    32'd0);
        align();
        sys_reset = 1'b1;
        repeat (10) @(posedge clk);
        #1;

        // ---------------- single byte with exact latency ----------------
        fork
            send_frame(8'hA5, 1'b1);
            begin
                repeat (155) @(posedge clk);   // edge E0+154: stop sample
                @(negedge clk);
                check_eq("a5 valid@154", 32'(data_valid), 32'd0);
                @(negedge clk);                // after edge E0+155
                check_eq("a5 valid@155", 32'(data_valid), 32'd1);
                check_eq("a5 data",      32'(data_out),   32'hA5);
                check_eq("a5 count",     32'(fifo_count), 32'd1);
            end
        join
        pop_check("a5 pop", 8'hA5);
        @(negedge clk);
        check_eq("a5 valid after pop", 32'(data_valid), 32'd0);
        check_eq("a5 count after pop", 32'(fifo_count), 32'd0);

        // ---------------- glitch ----------------
        align();
        rx = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (40) @(posedge clk);
        @(negedge clk);
        check_eq("glitch count",     32'(fifo_count), 32'd0);
        check_eq("glitch valid",     32'(data_valid), 32'd0);
        check_eq("glitch frame_err", 32'(frame_err),  32'd0);
        check_eq("glitch overrun",   32'(overrun),    32'd0);
        align();
        send_frame(8'h3C, 1'b1);
        @(negedge clk);
        check_eq("3c count", 32'(fifo_count), 32'd1);
        pop_check("3c pop", 8'h3C);

        // ---------------- frame error + break ----------------
        align();
        send_frame(8'h55, 1'b0);
        rx = 1'b0;
        repeat (40 * CLK_DIV) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (2 * CLK_DIV) @(posedge clk);
        @(negedge clk);
        check_eq("ferr flag",  32'(frame_err),  32'd1);
        check_eq("ferr count", 32'(fifo_count), 32'd0);
        align();
        send_frame(8'h81, 1'b1);
        @(negedge clk);
        check_eq("81 count", 32'(fifo_count), 32'd1);
        pop_check("81 pop", 8'h81);
        check_eq("ferr still set", 32'(frame_err), 32'd1);
        pulse_clear();
        @(negedge clk);
        check_eq("ferr cleared", 32'(frame_err), 32'd0);

        // ---------------- overrun ----------------
        align();
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), 1'b1);
        end
        repeat (4) @(negedge clk);
        check_eq("ovr count", 32'(fifo_count), 32'd4);
        check_eq("ovr flag",  32'(overrun),    32'd1);
        pop_check("ovr pop1", 8'h01);
        pop_check("ovr pop2", 8'h02);
        pop_check("ovr pop3", 8'h03);
        pop_check("ovr pop4", 8'h04);
        @(negedge clk);
        check_eq("ovr drained", 32'(data_valid), 32'd0);
        pulse_clear();
        @(negedge clk);
        check_eq("ovr cleared", 32'(overrun), 32'd0);

        // ---------------- full plus simultaneous pop ----------------
        align();
        for (int i = 0; i < 4; i++) begin
            send_frame(8'(8'h11 + i), 1'b1);
        end
        @(negedge clk);
        check_eq("full count", 32'(fifo_count), 32'd4);
        #1;
        fork
            send_frame(8'h15, 1'b1);
            begin
                repeat (155) @(posedge clk);   // edge E0+154
                @(negedge clk);
                data_ready = 1'b1;              // held across edge E0+155
                @(posedge clk);
                #1;
                data_ready = 1'b0;
            end
        join
        @(negedge clk);
        check_eq("fullpop count",   32'(fifo_count), 32'd4);
        check_eq("fullpop overrun", 32'(overrun),    32'd0);
        pop_check("fullpop pop1", 8'h12);
        pop_check("fullpop pop2", 8'h13);
        pop_check("fullpop pop3", 8'h14);
        pop_check("fullpop pop4", 8'h15);
        @(negedge clk);
        check_eq("fullpop drained", 32'(fifo_count), 32'd0);

        // ---------------- reset mid-frame ----------------
        align();
        fork
            send_frame(8'hF0, 1'b1);
            begin
                repeat (66) @(posedge clk);    // edge E0+65, inside bit 3
                #1;
                sys_reset = 1'b0;
                #1;
                check_eq("midrst data_out", 32'(data_out),   32'd0);
                check_eq("midrst valid",    32'(data_valid), 32'd0);
                check_eq("midrst count",    32'(fifo_count), 32'd0);
                check_eq("midrst ferr",     32'(frame_err),  32'd0);
                check_eq("midrst overrun",  32'(overrun),    32'd0);
                repeat (2) @(posedge clk);
                #1;
                sys_reset = 1'b1;              // line still low (bit 3)
            end
        join
        repeat (120) @(posedge clk);
        @(negedge clk);
        check_eq("midrst no push",  32'(fifo_count), 32'd0);
        check_eq("midrst no ferr",  32'(frame_err),  32'd0);
        align();
        send_frame(8'h0F, 1'b1);
        @(negedge clk);
        check_eq("0f count", 32'(fifo_count), 32'd1);
        pop_check("0f pop", 8'h0F);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
